// File: rtl/bus_pkg.sv
// Shared constants for the bus arbiter: bus-driver source codes and FSM state encoding.
// Codes 0-24 map onto the 25 drive enables; 25-31 are unused and flagged invalid.
package bus_pkg;
  localparam int NUM_SRC = 25;
  localparam int SRC_W   = 5;

  localparam logic [SRC_W-1:0] SRC_R0  = 5'd0,  SRC_R1  = 5'd1,  SRC_R2  = 5'd2,  SRC_R3  = 5'd3;
  localparam logic [SRC_W-1:0] SRC_R4  = 5'd4,  SRC_R5  = 5'd5,  SRC_R6  = 5'd6,  SRC_R7  = 5'd7;
  localparam logic [SRC_W-1:0] SRC_R8  = 5'd8,  SRC_R9  = 5'd9,  SRC_R10 = 5'd10, SRC_R11 = 5'd11;
  localparam logic [SRC_W-1:0] SRC_R12 = 5'd12, SRC_R13 = 5'd13, SRC_R14 = 5'd14, SRC_R15 = 5'd15;
  localparam logic [SRC_W-1:0] SRC_HI  = 5'd16, SRC_LO  = 5'd17, SRC_ZHI = 5'd18, SRC_ZLO = 5'd19;
  localparam logic [SRC_W-1:0] SRC_ZMUX = 5'd20, SRC_PC = 5'd21, SRC_MDR = 5'd22, SRC_PORTIN = 5'd23;
  localparam logic [SRC_W-1:0] SRC_CSIGN = 5'd24;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_OWN  = 1'b1
  } state_e;
endpackage

// File: rtl/bus_src_decode.sv
// Source code to one-hot drive-enable decode; pure combinational, no backpressure.
// Codes above SRC_CSIGN yield all-zero enables and raise o_invalid.
module bus_src_decode
  import bus_pkg::*;
(
  input  logic [SRC_W-1:0]   i_code,
  output logic [NUM_SRC-1:0] o_onehot,
  output logic               o_invalid
);

  always_comb begin
    o_invalid = (i_code > SRC_CSIGN);
    o_onehot  = '0;
    if (!o_invalid) o_onehot[i_code] = 1'b1;
  end

endmodule

// File: rtl/bus_arbiter.sv
// Round-robin bus arbiter with registered one-hot grant and drive enables; 1-cycle grant latency, owner may extend via hold.
// Optional BUS_ARB_TIMEOUT_EN: bounds a hold to MAX_HOLD cycles and masks the offender until it drops req.
module bus_arbiter
  import bus_pkg::*;
#(
  parameter int NUM_REQ  = 4,
  parameter int MAX_HOLD = 16
) (
  input  logic                     clock,
  input  logic                     clear,
  input  logic [NUM_REQ-1:0]       req,
  input  logic [SRC_W*NUM_REQ-1:0] req_src,
  input  logic [NUM_REQ-1:0]       hold,
  output logic [NUM_REQ-1:0]       gnt,
  output logic [NUM_SRC-1:0]       out_en,
  output logic                     busy,
  output logic                     src_err,
  output logic                     timeout_err
);

  localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  state_e               r_state, w_state_nxt;
  logic [PW-1:0]        r_ptr, r_owner, w_win;
  logic [NUM_REQ-1:0]   r_gnt, w_cand;
  logic [NUM_SRC-1:0]   r_out_en, w_dec;
  logic                 r_src_err, w_dec_inv;
  logic [SRC_W-1:0]     w_win_src;
  logic                 w_found, w_owner_wants, w_keep, w_load, w_revoke;

  assign w_owner_wants = (r_state == ST_OWN) && hold[r_owner] && req[r_owner];
  assign w_keep        = w_owner_wants && !w_revoke;

`ifdef BUS_ARB_TIMEOUT_EN
  localparam int CW = ($clog2(MAX_HOLD + 1) < 4) ? 4 : $clog2(MAX_HOLD + 1);

  logic [CW-1:0]      r_hold_cnt;
  logic [NUM_REQ-1:0] r_mask;
  logic               r_tmo_err;

  assign w_revoke    = w_owner_wants && (r_hold_cnt == CW'(MAX_HOLD));
  assign w_cand      = req & ~r_mask & ~({NUM_REQ{w_revoke}} & r_gnt);
  assign timeout_err = r_tmo_err;

  // Mask stays set until the revoked requester lets go of req.
  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      r_hold_cnt <= '0;
      r_mask     <= '0;
      r_tmo_err  <= 1'b0;
    end else begin
      r_tmo_err <= w_revoke;
      r_mask    <= (r_mask & req) | ({NUM_REQ{w_revoke}} & r_gnt);
      if (w_load)      r_hold_cnt <= CW'(1);
      else if (w_keep) r_hold_cnt <= r_hold_cnt + 1'b1;
      else             r_hold_cnt <= '0;
    end
  end
`else
  assign w_revoke    = 1'b0;
  assign w_cand      = req;
  assign timeout_err = 1'b0;
`endif

  always_comb begin
    int k;
    k       = 0;
    w_found = 1'b0;
    w_win   = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      k = int'(r_ptr) + i;
      if (k >= NUM_REQ) k = k - NUM_REQ;
      if (!w_found && w_cand[k]) begin
        w_found = 1'b1;
        w_win   = PW'(k);
      end
    end
  end

  assign w_win_src = req_src[int'(w_win)*SRC_W +: SRC_W];

  bus_src_decode u_dec (
    .i_code    (w_win_src),
    .o_onehot  (w_dec),
    .o_invalid (w_dec_inv)
  );

  always_ff @(posedge clock or posedge clear) begin
    if (clear) r_state <= ST_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (w_found) w_state_nxt = ST_OWN;
      ST_OWN:  if (!w_keep && !w_found) w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // A release with a pending request regrants on the same edge.
  always_comb begin
    w_load = 1'b0;
    case (r_state)
      ST_IDLE: w_load = w_found;
      ST_OWN:  w_load = !w_keep && w_found;
      default: w_load = 1'b0;
    endcase
  end

  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      r_gnt     <= '0;
      r_out_en  <= '0;
      r_owner   <= '0;
      r_ptr     <= '0;
      r_src_err <= 1'b0;
    end else begin
      r_src_err <= 1'b0;
      if (w_load) begin
        r_gnt     <= NUM_REQ'(1) << w_win;
        r_owner   <= w_win;
        r_out_en  <= w_dec;
        r_src_err <= w_dec_inv;
        r_ptr     <= (int'(w_win) == NUM_REQ - 1) ? '0 : w_win + 1'b1;
      end else if (!w_keep) begin
        r_gnt    <= '0;
        r_out_en <= '0;
      end
    end
  end

  assign gnt     = r_gnt;
  assign out_en  = r_out_en;
  assign busy    = |r_gnt;
  assign src_err = r_src_err;

endmodule

// File: doc/bus_arbiter.md
BUS_ARBITER -- requirements
Module: bus_arbiter

Interface
REQ-001 The block SHALL have one clock; reset is asynchronous and active-high.
REQ-002 Parameter NUM_REQ, default 4, SHALL set the number of requesters.
REQ-003 Parameter MAX_HOLD, default 16, SHALL set the maximum grant length in cycles.
REQ-004 Port clock, input, 1, SHALL be the rising-edge clock.
REQ-005 Port clear, input, 1, SHALL be the asynchronous active-high reset.
REQ-006 Port req, input, NUM_REQ, SHALL carry per-requester bus requests; bit 0 is the control unit.
REQ-007 Port req_src, input, 5*NUM_REQ, SHALL carry each requester's 5-bit source code; slice i belongs to requester i.
REQ-008 Port hold, input, NUM_REQ, SHALL let the current owner extend its grant.
REQ-009 Port gnt, output, NUM_REQ, SHALL carry the one-hot grant, registered.
REQ-010 Port out_en, output, 25, SHALL carry one-hot bus drive enables, registered, with this bit order: 0-15 R0-R15, 16 HI, 17 LO, 18 ZHI, 19 ZLO, 20 ZMux, 21 PC, 22 MDR, 23 PortIn, 24 CSign.
REQ-011 Port busy, output, 1, SHALL be high whenever any gnt bit is high.
REQ-012 Port src_err, output, 1, SHALL give a one-cycle pulse when a granted source code is 25-31.
REQ-013 Port timeout_err, output, 1, SHALL give a one-cycle pulse when a grant is forcibly revoked.

Function
REQ-014 The FSM SHALL have two states: IDLE (no grant) and OWN (one grant active).
REQ-015 In IDLE with any req bit high at edge N, the winner SHALL see gnt and out_en asserted after edge N, giving 1-cycle latency.
REQ-016 Arbitration SHALL be round-robin: search starts at the requester after the last owner, and the pointer resets to requester 0 as the highest priority.
REQ-017 out_en SHALL be the one-hot decode of the winner's req_src, captured at grant and held constant for the whole grant.
REQ-018 A source code of 25-31 SHALL still grant, but out_en SHALL be all-zero and src_err SHALL pulse in the first grant cycle.
REQ-019 A grant SHALL last one cycle unless the owner's hold is high at the edge, in which case OWN persists.
REQ-020 On release (hold low), the next owner SHALL be granted on the same edge if a request is pending (back-to-back, no idle cycle); otherwise the FSM returns to IDLE.
REQ-021 The owner dropping req while holding SHALL release the bus at that edge.
REQ-022 At most one gnt bit and at most one out_en bit SHALL be high in any cycle.
REQ-023 gnt and out_en SHALL never change except at a clock edge.

Reset
REQ-024 Asserting clear SHALL immediately force gnt=0, out_en=0, busy=0, src_err=0, timeout_err=0, state=IDLE, pointer=0 and hold counter=0, including in the middle of a grant.
REQ-025 After clear deasserts, the first grant SHALL occur no earlier than the first rising edge at which clear is low.

Configuration
REQ-026 With BUS_ARB_TIMEOUT_EN defined, a 4-bit+ hold counter SHALL revoke a grant after MAX_HOLD consecutive cycles, pulse timeout_err, and mask that requester until it deasserts req.
REQ-027 Without BUS_ARB_TIMEOUT_EN, no counter SHALL exist, grants SHALL be unbounded, and timeout_err SHALL be tied 0.

Structure
REQ-028 A shared package bus_pkg SHALL hold the source-code constants (SRC_R0..SRC_CSIGN), NUM_SRC=25 and the state enumeration.
REQ-029 A sub-module bus_src_decode (5-bit code to 25-bit one-hot, plus an invalid flag) SHALL be instantiated once.

Verification
REQ-030 A bench SHALL cover: req=0001, req_src[4:0]=21 -> after 1 edge gnt=0001, out_en bit 21 high, busy=1; with hold low, after the next edge gnt=0.
REQ-031 A bench SHALL cover: req=1111 held continuously for 8 cycles -> grants rotate 0001, 0010, 0100, 1000, 0001 with no idle gap.
REQ-032 A bench SHALL cover: owner 2 holds for 5 cycles while req0 is high -> gnt=0100 for 5 cycles, then gnt=0001 on the release edge.
REQ-033 A bench SHALL cover: req_src=27 -> gnt asserted, out_en=0, src_err pulses for exactly 1 cycle.
REQ-034 A bench SHALL cover, with BUS_ARB_TIMEOUT_EN: hold stuck high -> gnt drops after 16 cycles, timeout_err pulses, and the requester is not regranted until req toggles low.
REQ-035 A bench SHALL cover: clear pulsed mid-grant between edges -> gnt and out_en go to 0 immediately, and the round-robin pointer restarts at requester 0.
